// File: rtl/iob_reset_seq_pkg.sv
// Shared types and helpers for the reset/init sequencer.
package iob_reset_seq_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states; the encoding is visible on state_o.
    typedef enum logic [STATE_W-1:0] {
        ST_WAIT    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // Counter width big enough to hold the largest of the three cycle counts.
    function automatic int unsigned cnt_width(input int unsigned hold,
                                              input int unsigned stagger,
                                              input int unsigned timeout);
        int unsigned m;
        m = hold;
        if (stagger > m) m = stagger;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iob_reset_seq_if.sv
// Control/status bundle between the reset sequencer and its wrapper.
interface iob_reset_seq_if #(
    parameter int unsigned N_READY = 3,
    parameter int unsigned N_OUT   = 2
) ();
    import iob_reset_seq_pkg::*;

    logic [N_READY-1:0] ready_i;
    logic               soft_rst_i;
    logic               clear_i;
    logic [N_OUT-1:0]   rst_o;
    logic               done_o;
    logic               timeout_o;
    logic               loss_o;
    logic [N_READY-1:0] ready_sync_o;
    logic [STATE_W-1:0] state_o;

    // Wrapper side: drives readiness and control pulses, observes status.
    modport master (
        output ready_i, soft_rst_i, clear_i,
        input  rst_o, done_o, timeout_o, loss_o, ready_sync_o, state_o
    );

    // Sequencer side.
    modport slave (
        input  ready_i, soft_rst_i, clear_i,
        output rst_o, done_o, timeout_o, loss_o, ready_sync_o, state_o
    );

endinterface

// File: rtl/iob_reset_seq_sync.sv
// Multi-flop synchroniser for a vector of independent asynchronous levels.
module iob_reset_seq_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift each bit through STAGES flops; cleared to "not ready" on reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[STAGES-1];

endmodule

// File: rtl/iob_reset_seq.sv
// Reset/init sequencer: waits for all unmasked ready inputs to be stable,
// then releases the reset domains one at a time, watching for loss and timeout.
module iob_reset_seq
    import iob_reset_seq_pkg::*;
#(
    parameter int unsigned          N_READY         = 3,
    parameter logic [N_READY-1:0]   READY_MASK      = '1,
    parameter int unsigned          N_OUT           = 2,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter int unsigned          HOLD_CYCLES     = 16,
    parameter int unsigned          STAGGER_CYCLES  = 4,
    parameter int unsigned          TIMEOUT_CYCLES  = 1024,
    parameter bit                   RESTART_ON_LOSS = 1'b1
) (
    input  logic          clk_i,
    input  logic          arst_i,
    iob_reset_seq_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned IDX_W = $clog2(N_OUT) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    // tcnt parks one past the flag point so a cleared flag stays cleared.
    localparam logic [CNT_W-1:0] TO_SAT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_OUT-1:0]   rst_q, rst_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               loss_q, loss_d;
    logic               timeout_set, loss_set;
    logic [N_READY-1:0] ready_sync;
    logic               all_ok_c;

    iob_reset_seq_sync #(
        .WIDTH  (N_READY),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (bus.ready_i),
        .q_o    (ready_sync)
    );

    // Masked-off inputs count as permanently ready.
    assign all_ok_c = &(ready_sync | ~READY_MASK);

    // State register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: soft reset, then loss, then the normal sequence.
    always_comb begin
        state_d = state_q;
        if (bus.soft_rst_i) begin
            state_d = ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (all_ok_c) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!all_ok_c)              state_d = ST_WAIT;
                    else if (cnt_q == HOLD_LAST) state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!all_ok_c)
                        state_d = ST_WAIT;
                    else if (cnt_q == STAG_LAST && idx_q == IDX_LAST)
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!all_ok_c && RESTART_ON_LOSS) state_d = ST_WAIT;
                end
                default: state_d = ST_WAIT;
            endcase
        end
    end

    // Counters, reset vector and sticky flags for the coming cycle.
    always_comb begin
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        idx_d       = idx_q;
        rst_d       = rst_q;
        timeout_d   = timeout_q;
        loss_d      = loss_q;
        timeout_set = 1'b0;
        loss_set    = 1'b0;

        if (bus.soft_rst_i) begin
            rst_d  = '1;
            cnt_d  = '0;
            tcnt_d = '0;
            idx_d  = '0;
        end else begin
            // Init timeout runs through every pre-RUN state, ignoring HOLD bounces.
            if (state_q != ST_RUN && TO_EN) begin
                if (tcnt_q != TO_SAT)  tcnt_d      = tcnt_q + CNT_W'(1);
                if (tcnt_q == TO_LAST) timeout_set = 1'b1;
            end

            case (state_q)
                ST_WAIT: begin
                    rst_d = '1;
                    cnt_d = '0;
                    idx_d = '0;
                end
                ST_HOLD: begin
                    if (!all_ok_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!all_ok_c) begin
                        loss_set = 1'b1;
                        rst_d    = '1;
                        cnt_d    = '0;
                        idx_d    = '0;
                        tcnt_d   = '0;
                    end else if (cnt_q == STAG_LAST) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) tcnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!all_ok_c) begin
                        loss_set = 1'b1;
                        if (RESTART_ON_LOSS) begin
                            rst_d  = '1;
                            cnt_d  = '0;
                            idx_d  = '0;
                            tcnt_d = '0;
                        end
                    end
                end
                default: begin
                    rst_d = '1;
                end
            endcase
        end

        // A same-cycle set beats clear.
        if (bus.clear_i) begin
            timeout_d = 1'b0;
            loss_d    = 1'b0;
        end
        if (timeout_set) timeout_d = 1'b1;
        if (loss_set)    loss_d    = 1'b1;

        done_d = (state_d == ST_RUN);
    end

    // Datapath and output registers; rst_o comes straight from flops.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q     <= '0;
            tcnt_q    <= '0;
            idx_q     <= '0;
            rst_q     <= '1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            loss_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            idx_q     <= idx_d;
            rst_q     <= rst_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            loss_q    <= loss_d;
        end
    end

    assign bus.rst_o        = rst_q;
    assign bus.done_o       = done_q;
    assign bus.timeout_o    = timeout_q;
    assign bus.loss_o       = loss_q;
    assign bus.ready_sync_o = ready_sync;
    assign bus.state_o      = STATE_W'(state_q);

endmodule

// File: tb/tb_iob_reset_seq.sv
// Scoreboard bench for iob_reset_seq: a default instance (a) and a masked,
// flag-only-on-loss instance (b) share clock and async reset.
module tb_iob_reset_seq;
    import iob_reset_seq_pkg::*;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    iob_reset_seq_if #(.N_READY(3), .N_OUT(2)) bus_a ();
    iob_reset_seq_if #(.N_READY(3), .N_OUT(2)) bus_b ();

    iob_reset_seq #(
        .N_READY(3), .READY_MASK(3'b111), .N_OUT(2), .SYNC_STAGES(2),
        .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .TIMEOUT_CYCLES(1024),
        .RESTART_ON_LOSS(1'b1)
    ) dut_a (.clk_i(clk), .arst_i(arst), .bus(bus_a));

    iob_reset_seq #(
        .N_READY(3), .READY_MASK(3'b011), .N_OUT(2), .SYNC_STAGES(2),
        .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .TIMEOUT_CYCLES(1024),
        .RESTART_ON_LOSS(1'b0)
    ) dut_b (.clk_i(clk), .arst_i(arst), .bus(bus_b));

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    typedef enum int {
        S_RST_A, S_DONE_A, S_LOSS_A, S_TO_A, S_ST_A, S_SYNC_A,
        S_RST_B, S_DONE_B, S_LOSS_B, S_ST_B
    } sel_e;

    typedef struct {
        int unsigned cyc;
        sel_e        sel;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] observe(input sel_e s);
        case (s)
            S_RST_A:  return 16'(bus_a.rst_o);
            S_DONE_A: return 16'(bus_a.done_o);
            S_LOSS_A: return 16'(bus_a.loss_o);
            S_TO_A:   return 16'(bus_a.timeout_o);
            S_ST_A:   return 16'(bus_a.state_o);
            S_SYNC_A: return 16'(bus_a.ready_sync_o);
            S_RST_B:  return 16'(bus_b.rst_o);
            S_DONE_B: return 16'(bus_b.done_o);
            S_LOSS_B: return 16'(bus_b.loss_o);
            S_ST_B:   return 16'(bus_b.state_o);
            default:  return 16'hdead;
        endcase
    endfunction

    // Queue an expectation d clock edges after the current negedge.
    task automatic expect_at(input int unsigned d, input sel_e s, input logic [15:0] v,
                             input string tag);
        exp_t e;
        e.cyc = cyc + d;
        e.sel = s;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edge counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Pop and compare every expectation that falls due on this negedge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.ready_i = 3'b000; bus_a.soft_rst_i = 1'b0; bus_a.clear_i = 1'b0;
        bus_b.ready_i = 3'b000; bus_b.soft_rst_i = 1'b0; bus_b.clear_i = 1'b0;

        // 1: reset values, then a clean sequence on both instances.
        step(1);
        check("rst_a_reset",   16'(bus_a.rst_o),   16'h3);
        check("done_a_reset",  16'(bus_a.done_o),  16'h0);
        check("state_a_reset", 16'(bus_a.state_o), 16'h0);
        step(4);
        arst = 1'b0;
        bus_a.ready_i = 3'b111;
        bus_b.ready_i = 3'b011;
        expect_at(1,  S_SYNC_A, 16'h0, "sync_a_lat1");
        expect_at(2,  S_SYNC_A, 16'h7, "sync_a_lat2");
        expect_at(2,  S_ST_A,   16'h0, "t1_wait");
        expect_at(3,  S_ST_A,   16'h1, "t1_hold");
        expect_at(3,  S_RST_A,  16'h3, "t1_rst_hold");
        expect_at(18, S_ST_A,   16'h1, "t1_hold_end");
        expect_at(19, S_ST_A,   16'h2, "t1_release");
        expect_at(22, S_RST_A,  16'h3, "t1_rst_pre0");
        expect_at(23, S_RST_A,  16'h2, "t1_rst0");
        expect_at(26, S_RST_A,  16'h2, "t1_rst_pre1");
        expect_at(26, S_DONE_A, 16'h0, "t1_done_pre");
        expect_at(27, S_RST_A,  16'h0, "t1_rst1");
        expect_at(27, S_DONE_A, 16'h1, "t1_done");
        expect_at(27, S_ST_A,   16'h3, "t1_run");
        expect_at(27, S_RST_B,  16'h0, "t1_b_rst");
        expect_at(27, S_DONE_B, 16'h1, "t1_b_done");
        step(30);

        // 3: ready loss in RUN; a restarts, b only flags.
        bus_a.ready_i = 3'b011;
        bus_b.ready_i = 3'b001;
        expect_at(2, S_RST_A,  16'h0, "t3_a_rst_pre");
        expect_at(2, S_LOSS_A, 16'h0, "t3_a_loss_pre");
        expect_at(3, S_RST_A,  16'h3, "t3_a_rst");
        expect_at(3, S_DONE_A, 16'h0, "t3_a_done");
        expect_at(3, S_LOSS_A, 16'h1, "t3_a_loss");
        expect_at(3, S_ST_A,   16'h0, "t3_a_wait");
        expect_at(2, S_LOSS_B, 16'h0, "t3_b_loss_pre");
        expect_at(3, S_LOSS_B, 16'h1, "t3_b_loss");
        expect_at(3, S_RST_B,  16'h0, "t3_b_rst");
        expect_at(3, S_ST_B,   16'h3, "t3_b_run");
        expect_at(6, S_RST_B,  16'h0, "t3_b_rst_hold");
        step(8);

        // 2: bounce out of HOLD at cnt=10, then a full hold from scratch.
        bus_a.ready_i = 3'b111;
        expect_at(3, S_ST_A, 16'h1, "t2_hold");
        step(13);
        bus_a.ready_i = 3'b101;
        expect_at(2, S_ST_A,  16'h1, "t2_still_hold");
        expect_at(3, S_ST_A,  16'h0, "t2_bounce");
        expect_at(3, S_RST_A, 16'h3, "t2_bounce_rst");
        step(3);
        bus_a.ready_i = 3'b111;
        expect_at(3,  S_ST_A,   16'h1, "t2_rehold");
        expect_at(18, S_ST_A,   16'h1, "t2_rehold_end");
        expect_at(19, S_ST_A,   16'h2, "t2_release");
        expect_at(22, S_RST_A,  16'h3, "t2_rst_pre0");
        expect_at(23, S_RST_A,  16'h2, "t2_rst0");
        expect_at(27, S_RST_A,  16'h0, "t2_rst1");
        expect_at(27, S_DONE_A, 16'h1, "t2_done");
        expect_at(27, S_LOSS_A, 16'h1, "t2_loss_sticky");
        step(30);

        // clear: a's flag drops; b still sees loss that cycle, so set wins.
        bus_a.clear_i = 1'b1;
        bus_b.clear_i = 1'b1;
        expect_at(1, S_LOSS_A, 16'h0, "clr_a_loss");
        expect_at(1, S_DONE_A, 16'h1, "clr_a_done");
        expect_at(1, S_LOSS_B, 16'h1, "clr_b_set_wins");
        step(1);
        bus_a.clear_i = 1'b0;
        bus_b.clear_i = 1'b0;
        bus_b.ready_i = 3'b011;
        step(2);

        // 5: soft reset of masked instance in RUN, then full resequence.
        bus_b.soft_rst_i = 1'b1;
        expect_at(1,  S_RST_B,  16'h3, "t5_rst");
        expect_at(1,  S_DONE_B, 16'h0, "t5_done");
        expect_at(1,  S_ST_B,   16'h0, "t5_wait");
        expect_at(1,  S_LOSS_B, 16'h1, "t5_loss_kept");
        expect_at(2,  S_ST_B,   16'h1, "t5_hold");
        expect_at(21, S_RST_B,  16'h3, "t5_rst_pre0");
        expect_at(22, S_RST_B,  16'h2, "t5_rst0");
        expect_at(26, S_RST_B,  16'h0, "t5_rst1");
        expect_at(26, S_DONE_B, 16'h1, "t5_done_run");
        step(1);
        bus_b.soft_rst_i = 1'b0;
        step(29);

        // 4: init timeout with ready_i[0] held low.
        arst = 1'b1;
        bus_a.ready_i = 3'b110;
        step(5);
        arst = 1'b0;
        expect_at(2,    S_SYNC_A, 16'h6, "t4_sync");
        expect_at(1023, S_TO_A,   16'h0, "t4_to_pre");
        expect_at(1024, S_TO_A,   16'h1, "t4_to");
        expect_at(1024, S_RST_A,  16'h3, "t4_rst");
        expect_at(1024, S_ST_A,   16'h0, "t4_wait");
        expect_at(1100, S_TO_A,   16'h1, "t4_to_sticky");
        expect_at(27,   S_DONE_B, 16'h1, "t4_b_done");
        step(1101);
        bus_a.clear_i = 1'b1;
        expect_at(1,  S_TO_A, 16'h0, "t4_clear");
        expect_at(10, S_TO_A, 16'h0, "t4_clear_stays");
        step(1);
        bus_a.clear_i = 1'b0;
        bus_a.ready_i = 3'b111;
        expect_at(3,  S_ST_A,   16'h1, "t4_hold");
        expect_at(23, S_RST_A,  16'h2, "t4_rst0");
        expect_at(27, S_RST_A,  16'h0, "t4_rst1");
        expect_at(27, S_DONE_A, 16'h1, "t4_done");
        step(30);

        // 6: async reset in the middle of RELEASE.
        bus_a.soft_rst_i = 1'b1;
        expect_at(1,  S_RST_A, 16'h3, "t6_soft_rst");
        expect_at(2,  S_ST_A,  16'h1, "t6_hold");
        expect_at(22, S_RST_A, 16'h2, "t6_rst0");
        expect_at(22, S_ST_A,  16'h2, "t6_release");
        step(1);
        bus_a.soft_rst_i = 1'b0;
        step(23);
        check("t6_pre_rst", 16'(bus_a.rst_o), 16'h2);
        arst = 1'b1;
        #1;
        check("t6_arst_rst",   16'(bus_a.rst_o),        16'h3);
        check("t6_arst_done",  16'(bus_a.done_o),       16'h0);
        check("t6_arst_to",    16'(bus_a.timeout_o),    16'h0);
        check("t6_arst_loss",  16'(bus_a.loss_o),       16'h0);
        check("t6_arst_state", 16'(bus_a.state_o),      16'h0);
        check("t6_arst_sync",  16'(bus_a.ready_sync_o), 16'h0);
        check("t6_arst_b_rst", 16'(bus_b.rst_o),        16'h3);
        step(2);
        arst = 1'b0;
        expect_at(3,  S_ST_A,   16'h1, "t6_rehold");
        expect_at(23, S_RST_A,  16'h2, "t6_rerst0");
        expect_at(27, S_RST_A,  16'h0, "t6_rerst1");
        expect_at(27, S_DONE_A, 16'h1, "t6_redone");
        step(30);

        step(3);
        check("sb_drain", 16'(sb.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
